pwm_axil_responder: RTL and testbench

- AXI4-Lite slave (responder) register file for the PWM IP, with the PWM generator it controls; the bus master VIP/CPU is the initiator.
- Four 32-bit registers: CTRL (0x0), PERIOD (0x4), DUTY (0x8), SCRATCH (0xC). All are fully read/write, so every written word reads back unchanged.
- Drives one PWM output plus a period tick; sits behind the AXI interconnect in the IP top level.

---
 rtl/pwm_axil_pkg.sv | 31 +++
 rtl/pwm_core.sv | 75 +++++++
 rtl/pwm_axil_responder.sv | 166 ++++++++++++++++
 tb/tb_pwm_axil_responder.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_axil_pkg.sv
// Shared constants and helpers for the PWM AXI4-Lite register block.
package pwm_axil_pkg;

  // Register index taken from address bits [3:2].
  typedef logic [1:0] reg_idx_t;

  localparam reg_idx_t REG_CTRL    = 2'd0;
  localparam reg_idx_t REG_PERIOD  = 2'd1;
  localparam reg_idx_t REG_DUTY    = 2'd2;
  localparam reg_idx_t REG_SCRATCH = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;

  // The block never signals an error.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte-lane merge of a write into the current register value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM generator: free-running counter, period/duty shadows loaded at the
// period boundary, registered output and end-of-period tick.
module pwm_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             polarity,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             period_tick
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH-1:0] duty_s;
  logic             running;
  logic             at_wrap;
  logic             load_shadow;
  logic             raw;
  logic             tick_next;

  // Decode counter position, shadow-load condition and the raw compare.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here by straight-line assignment) so no latch can be inferred.
  always_comb begin
    running     = enable && (period_s != '0);
    at_wrap     = (cnt == period_s - ONE);
    // A zero period has no wrap point, so the shadows keep tracking the
    // live registers until a non-zero period is picked up.
    load_shadow = !running || at_wrap;
    raw         = running && (cnt < duty_s);
    tick_next   = running && at_wrap;
  end

  // Counter: holds at 0 when idle, otherwise counts 0..period_s-1.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!running || at_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  // Shadow registers: new PERIOD/DUTY take effect only at a period boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_s <= '0;
      duty_s   <= '0;
    end else if (load_shadow) begin
      period_s <= period;
      duty_s   <= duty;
    end
  end

  // Registered outputs, both one cycle behind the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      pwm_out     <= raw ^ polarity;
      period_tick <= tick_next;
    end
  end

endmodule

// File: rtl/pwm_axil_responder.sv
// AXI4-Lite responder with four read/write registers (CTRL, PERIOD, DUTY,
// SCRATCH) driving the PWM core.
module pwm_axil_responder
  import pwm_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_WIDTH          = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            period_tick
);

  // Write-address and write-data holds.
  logic        aw_held;
  reg_idx_t    aw_idx;
  logic        w_held;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid;

  // Read channel state.
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] rd_mux;

  // Register file.
  logic [31:0] ctrl_q;
  logic [31:0] period_q;
  logic [31:0] duty_q;
  logic [31:0] scratch_q;

  logic aw_fire;
  logic w_fire;
  logic ar_fire;
  logic commit;

  // Address low bits, protection and spare CTRL bits carry no function.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], ctrl_q[31:2]};

  // Ready flags are held low throughout reset.
  assign S_AXI_AWREADY = ARESETN && !aw_held;
  assign S_AXI_WREADY  = ARESETN && !w_held;
  assign S_AXI_ARREADY = ARESETN && !rvalid;

  assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
  // A write commits once both halves are held and the response slot is free.
  assign commit  = aw_held && w_held && (!bvalid || S_AXI_BREADY);

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = RESP_OKAY;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = RESP_OKAY;

  // Write channel: capture AW and W independently, release both on commit.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      aw_idx  <= REG_CTRL;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[3:2];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register file update, byte-lane merged on commit.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ctrl_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      scratch_q <= '0;
    end else if (commit) begin
      unique case (aw_idx)
        REG_CTRL:    ctrl_q    <= apply_wstrb(ctrl_q,    w_data, w_strb);
        REG_PERIOD:  period_q  <= apply_wstrb(period_q,  w_data, w_strb);
        REG_DUTY:    duty_q    <= apply_wstrb(duty_q,    w_data, w_strb);
        REG_SCRATCH: scratch_q <= apply_wstrb(scratch_q, w_data, w_strb);
        default:     ;
      endcase
    end
  end

  // Read mux on the incoming address; a same-edge commit is not yet visible.
  always_comb begin
    rd_mux = '0;
    unique case (reg_idx_t'(S_AXI_ARADDR[3:2]))
      REG_CTRL:    rd_mux = ctrl_q;
      REG_PERIOD:  rd_mux = period_q;
      REG_DUTY:    rd_mux = duty_q;
      REG_SCRATCH: rd_mux = scratch_q;
      default:     rd_mux = '0;
    endcase
  end

  // Read channel: latch data on handshake, hold until RREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_mux;
    end else if (S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  pwm_core #(
    .WIDTH (PWM_WIDTH)
  ) u_core (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .enable      (ctrl_q[CTRL_EN]),
    .polarity    (ctrl_q[CTRL_POL]),
    .period      (period_q[PWM_WIDTH-1:0]),
    .duty        (duty_q[PWM_WIDTH-1:0]),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

endmodule

// File: tb/tb_pwm_axil_responder.sv
// Self-checking bench for pwm_axil_responder: register model for the bus
// side, arithmetic waveform expectations for the PWM side.
module tb_pwm_axil_responder;

  logic        ACLK          = 1'b0;
  logic        ARESETN       = 1'b0;
  logic [3:0]  S_AXI_AWADDR  = '0;
  logic [2:0]  S_AXI_AWPROT  = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA   = '0;
  logic [3:0]  S_AXI_WSTRB   = '0;
  logic        S_AXI_WVALID  = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY  = 1'b1;
  logic [3:0]  S_AXI_ARADDR  = '0;
  logic [2:0]  S_AXI_ARPROT  = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY  = 1'b1;
  logic        pwm_out;
  logic        period_tick;

  int n_cmp = 0;
  int n_err = 0;

  // Expected register contents, indexed by address bits [3:2].
  logic [31:0] model_regs [4];

  pwm_axil_responder dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .pwm_out       (pwm_out),
    .period_tick   (period_tick)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Full write transaction; updates the model and checks BRESP.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      if (aw_fire) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  S_AXI_WVALID  = 1'b0; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
    model_regs[addr[3:2]] = merge_bytes(model_regs[addr[3:2]], data, strb);
    n_cmp++;
    if (n >= 50) begin
      n_err++;
      $display("FAIL write_timeout addr=%h: no BVALID seen, required within 50 cycles", addr);
    end else if (S_AXI_BRESP !== 2'b00) begin
      n_err++;
      $display("FAIL bresp addr=%h: got %b, required 00", addr, S_AXI_BRESP);
    end
  endtask

  // Full read transaction; checks RRESP and returns the data.
  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    n = 0;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
    data = S_AXI_RDATA;
    n_cmp++;
    if (n >= 50) begin
      n_err++;
      $display("FAIL read_timeout addr=%h: no RVALID seen, required within 50 cycles", addr);
    end else if (S_AXI_RRESP !== 2'b00) begin
      n_err++;
      $display("FAIL rresp addr=%h: got %b, required 00", addr, S_AXI_RRESP);
    end
  endtask

  // Returns at the negedge sample where period_tick is first seen high.
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!period_tick && n < 200);
    if (!period_tick) begin
      n_cmp++; n_err++;
      $display("FAIL %s tick_timeout: no period_tick within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ready_low: got %b, required 000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_tick, S_AXI_AWREADY,
         S_AXI_WREADY, S_AXI_ARREADY} !== 7'b0000111) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 0000111",
               {S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_tick, S_AXI_AWREADY,
                S_AXI_WREADY, S_AXI_ARREADY});
    end
    n_cmp++;
    if (S_AXI_RDATA !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h, required 00000000", S_AXI_RDATA);
    end
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
  endtask

  task automatic test_basic_rw();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d);
      n_cmp++;
      if (d !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL basic_readback reg%0d: got %h, required %h", i, d, 32'(i + 1));
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    axi_write(4'hC, 32'h0, 4'hF);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0101);
    axi_read(4'hC, d);
    n_cmp++;
    if (d !== 32'h00BB00DD) begin
      n_err++;
      $display("FAIL strobe_0101: got %h, required 00BB00DD", d);
    end
    axi_write(4'hC, 32'hFFFFFFFF, 4'b0000);
    axi_read(4'hC, d);
    n_cmp++;
    if (d !== 32'h00BB00DD) begin
      n_err++;
      $display("FAIL strobe_none: got %h, required 00BB00DD", d);
    end
  endtask

  task automatic test_random_rw();
    logic [31:0] d;
    logic [3:0]  ra;
    for (int i = 0; i < 20; i++) begin
      axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      ra = 4'($urandom_range(0, 15));
      axi_read(ra, d);
      n_cmp++;
      if (d !== model_regs[ra[3:2]]) begin
        n_err++;
        $display("FAIL random_rw addr=%h: got %h, required %h", ra, d, model_regs[ra[3:2]]);
      end
    end
    axi_write(4'h0, 32'h0, 4'hF);
  endtask

  // AW in cycle 10, W in 14, BREADY only in 20; reads in 15 (commit cycle)
  // and 17 observe the old and new SCRATCH values.
  task automatic test_write_latency();
    logic [31:0] old_v, new_v;
    bit exp_awr, exp_wr, exp_bv;
    old_v = model_regs[3];
    new_v = $urandom;
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = new_v; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'hC;
    for (int k = 10; k <= 21; k++) begin
      @(negedge ACLK);
      exp_awr = !(k >= 11 && k <= 15);
      exp_wr  = (k != 15);
      exp_bv  = (k >= 16 && k <= 20);
      n_cmp++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== {exp_awr, exp_wr, exp_bv}) begin
        n_err++;
        $display("FAIL latency_flags cycle %0d: awready/wready/bvalid got %b, required %b",
                 k, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, {exp_awr, exp_wr, exp_bv});
      end
      if (k == 16 || k == 18) begin
        n_cmp++;
        if ({S_AXI_RVALID, S_AXI_RDATA} !== {1'b1, (k == 16) ? old_v : new_v}) begin
          n_err++;
          $display("FAIL latency_read cycle %0d: got rvalid=%b data=%h, required 1 %h",
                   k, S_AXI_RVALID, S_AXI_RDATA, (k == 16) ? old_v : new_v);
        end
      end
      S_AXI_AWVALID = (k == 10);
      S_AXI_WVALID  = (k == 14);
      S_AXI_BREADY  = (k == 20);
      S_AXI_ARVALID = (k == 15 || k == 17);
      S_AXI_RREADY  = 1'b1;
    end
    S_AXI_BREADY = 1'b1;
    model_regs[3] = new_v;
  endtask

  task automatic test_pwm_wave();
    bit ep, et;
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    wait_tick("pwm_wave");
    for (int i = 0; i < 30; i++) begin
      @(negedge ACLK);
      ep = (i % 10) < 3;
      et = (i % 10) == 9;
      n_cmp++;
      if ({pwm_out, period_tick} !== {ep, et}) begin
        n_err++;
        $display("FAIL pwm_wave i=%0d: pwm/tick got %b, required %b", i,
                 {pwm_out, period_tick}, {ep, et});
      end
    end
  endtask

  task automatic test_polarity();
    bit ep, et;
    axi_write(4'h0, 32'd3, 4'hF);
    wait_tick("polarity");
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      ep = !((i % 10) < 3);
      et = (i % 10) == 9;
      n_cmp++;
      if ({pwm_out, period_tick} !== {ep, et}) begin
        n_err++;
        $display("FAIL polarity_wave i=%0d: pwm/tick got %b, required %b", i,
                 {pwm_out, period_tick}, {ep, et});
      end
    end
    // Disabled with polarity set: output sits at the inactive level 1.
    axi_write(4'h0, 32'd2, 4'hF);
    repeat (2) @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      n_cmp++;
      if ({pwm_out, period_tick} !== 2'b10) begin
        n_err++;
        $display("FAIL disabled_polarity i=%0d: pwm/tick got %b, required 10", i,
                 {pwm_out, period_tick});
      end
    end
    axi_write(4'h0, 32'd1, 4'hF);
  endtask

  // DUTY rewritten early in a period must only apply from the next period.
  task automatic test_mid_period();
    wait_tick("mid_period");
    fork
      begin
        repeat (2) @(negedge ACLK);
        axi_write(4'h8, 32'd7, 4'hF);
      end
      begin
        bit ep, et;
        for (int i = 0; i < 20; i++) begin
          @(negedge ACLK);
          ep = (i % 10) < ((i < 10) ? 3 : 7);
          et = (i % 10) == 9;
          n_cmp++;
          if ({pwm_out, period_tick} !== {ep, et}) begin
            n_err++;
            $display("FAIL mid_period i=%0d: pwm/tick got %b, required %b", i,
                     {pwm_out, period_tick}, {ep, et});
          end
        end
      end
    join
  endtask

  task automatic test_random_pwm();
    int p, d;
    bit pol, ep, et;
    for (int it = 0; it < 4; it++) begin
      p   = $urandom_range(1, 12);
      d   = $urandom_range(0, p + 2);
      pol = 1'($urandom_range(0, 1));
      axi_write(4'h0, 32'd0, 4'hF);
      axi_write(4'h4, 32'(p), 4'hF);
      axi_write(4'h8, 32'(d), 4'hF);
      axi_write(4'h0, {30'd0, pol, 1'b1}, 4'hF);
      wait_tick("random_pwm");
      for (int i = 0; i < 2 * p; i++) begin
        @(negedge ACLK);
        ep = ((i % p) < d) ^ pol;
        et = (i % p) == (p - 1);
        n_cmp++;
        if ({pwm_out, period_tick} !== {ep, et}) begin
          n_err++;
          $display("FAIL random_pwm P=%0d D=%0d pol=%0d i=%0d: pwm/tick got %b, required %b",
                   p, d, pol, i, {pwm_out, period_tick}, {ep, et});
        end
      end
    end
  endtask

  // Reset while both a write response and read data are pending.
  task automatic test_reset_mid_txn();
    logic [31:0] d;
    axi_write(4'h0, 32'd2, 4'hF);
    @(negedge ACLK);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = $urandom; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if ({S_AXI_BVALID, S_AXI_RVALID, pwm_out} !== 3'b111) begin
      n_err++;
      $display("FAIL pre_reset_pending: bvalid/rvalid/pwm got %b, required 111",
               {S_AXI_BVALID, S_AXI_RVALID, pwm_out});
    end
    ARESETN = 1'b0;
    #1;
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset_ready_low: got %b, required 000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    n_cmp++;
    if ({S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_tick} !== 4'b0000 ||
        S_AXI_RDATA !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset: bvalid/rvalid/pwm/tick got %b rdata %h, required 0000 00000000",
               {S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_tick}, S_AXI_RDATA);
    end
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      n_cmp++;
      if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
        n_err++;
        $display("FAIL stale_response i=%0d: bvalid/rvalid got %b, required 00", i,
                 {S_AXI_BVALID, S_AXI_RVALID});
      end
    end
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d);
      n_cmp++;
      if (d !== model_regs[i]) begin
        n_err++;
        $display("FAIL reset_regs reg%0d: got %h, required %h", i, d, model_regs[i]);
      end
    end
  endtask

  task automatic test_zero_period();
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h8, 32'd5, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    for (int i = 0; i < 30; i++) begin
      @(negedge ACLK);
      n_cmp++;
      if ({pwm_out, period_tick} !== 2'b00) begin
        n_err++;
        $display("FAIL zero_period i=%0d: pwm/tick got %b, required 00", i,
                 {pwm_out, period_tick});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_strobe();
    test_random_rw();
    test_write_latency();
    test_pwm_wave();
    test_polarity();
    test_mid_period();
    test_random_pwm();
    test_reset_mid_txn();
    test_zero_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
